// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
// Contents:
//   DATA_W_DEF / NUM_REQ_DEF / ID_W_DEF / ID_W_MAX - default widths.
//   sched_state_t - result register occupancy (EMPTY / FULL).
//   result_t      - packed result record {id, sum, cout, overflow}.
//   signed_ovf()  - two's-complement overflow from the three sign bits.
package adder_sched_pkg;

  localparam int DATA_W_DEF  = 64;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);
  // Widest id needed for the largest supported requester count (8).
  localparam int ID_W_MAX    = 3;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [ID_W_MAX-1:0]   id;
    logic [DATA_W_DEF-1:0] sum;
    logic                  cout;
    logic                  overflow;
  } result_t;

  // Overflow when both operands share a sign and the sum's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_adder_64bit.sv
// Purely combinational 64-bit adder with carry in/out.
// Ports:
//   a, b  - 64-bit operands
//   cin   - carry-in
//   sum   - 64-bit sum
//   cout  - unsigned carry-out
module full_adder_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic [64:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {64'b0, cin};
  assign sum     = total_s[63:0];
  assign cout    = total_s[64];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping explicitly so non-power-of-two requester counts work.
// Ports:
//   req      - request vector
//   ptr      - highest-priority index for this cycle
//   en       - when low no grant is produced
//   gnt      - one-hot grant
//   gnt_idx  - encoded index of the granted requester
//   gnt_any  - a grant was produced
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic [ID_W:0]   cand_s;
  logic [ID_W-1:0] cand_idx_s;

  // Scan ptr, ptr+1, ... modulo NUM_REQ and take the first valid request.
  always_comb begin
    gnt        = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    cand_s     = '0;
    cand_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = cand_s[ID_W-1:0];
      if (en && !gnt_any && req[cand_idx_s]) begin
        gnt[cand_idx_s] = 1'b1;
        gnt_idx         = cand_idx_s;
        gnt_any         = 1'b1;
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one 64-bit adder between NUM_REQ requesters with round-robin
// arbitration. Each grant launches one add whose result is held in a
// one-entry output register until the consumer takes it. A carry register
// per requester lets a requester chain multi-word additions across grants.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   req_valid/req_ready   - per-requester handshake (req_ready is one-hot)
//   req_a, req_b          - packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_cin, req_chain    - carry-in, or use stored carry when chain=1
//   rsp_valid/rsp_ready   - result handshake
//   rsp_id, rsp_sum, rsp_cout, rsp_overflow - held result
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  input  logic [NUM_REQ-1:0]        req_chain,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic                      rsp_cout,
  output logic                      rsp_overflow
);

  sched_state_t       state_r, state_nxt_s;
  logic [ID_W-1:0]    ptr_r;
  logic [NUM_REQ-1:0] carry_r;
  result_t            res_r;

  logic               can_issue_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic               gnt_any_s;
  logic [DATA_W-1:0]  op_a_s, op_b_s, sum_s;
  logic               cin_s, cout_s, ovf_s;
  logic               unused_id_s;

  // A new op may launch when the register is free or being drained now.
  assign can_issue_s = (state_r == EMPTY) | rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_r),
    .en      (can_issue_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .gnt_any (gnt_any_s)
  );

  assign req_ready = gnt_s;

  assign op_a_s = req_a[gnt_idx_s*DATA_W +: DATA_W];
  assign op_b_s = req_b[gnt_idx_s*DATA_W +: DATA_W];
  // Chaining only ever consumes the granted requester's own carry.
  assign cin_s  = req_chain[gnt_idx_s] ? carry_r[gnt_idx_s] : req_cin[gnt_idx_s];

  full_adder_64bit u_add (
    .a    (op_a_s),
    .b    (op_b_s),
    .cin  (cin_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  assign ovf_s = signed_ovf(op_a_s[DATA_W-1], op_b_s[DATA_W-1], sum_s[DATA_W-1]);

  // Occupancy next-state: a grant always fills, a drain without grant empties.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (gnt_any_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (gnt_any_s) begin
          state_nxt_s = FULL;
        end else if (rsp_ready) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State, pointer, carry and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      ptr_r   <= '0;
      carry_r <= '0;
      res_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (gnt_any_s) begin
        res_r.id            <= ID_W_MAX'(gnt_idx_s);
        res_r.sum           <= sum_s;
        res_r.cout          <= cout_s;
        res_r.overflow      <= ovf_s;
        carry_r[gnt_idx_s]  <= cout_s;
        // Explicit wrap keeps non-power-of-two counts inside range.
        if (gnt_idx_s == ID_W'(NUM_REQ-1)) begin
          ptr_r <= '0;
        end else begin
          ptr_r <= gnt_idx_s + ID_W'(1);
        end
      end else begin
        res_r   <= res_r;
        ptr_r   <= ptr_r;
        carry_r <= carry_r;
      end
    end
  end

  assign rsp_valid    = (state_r == FULL);
  assign rsp_id       = res_r.id[ID_W-1:0];
  assign rsp_sum      = res_r.sum;
  assign rsp_cout     = res_r.cout;
  assign rsp_overflow = res_r.overflow;
  assign unused_id_s  = ^res_r.id;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed self-checking bench for adder_rr_scheduler (4 requesters, 64-bit).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_adder_rr_scheduler;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_chain;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           rsp_overflow;

  int vec_cnt;
  int err_cnt;

  adder_rr_scheduler #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .req_chain    (req_chain),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_cout     (rsp_cout),
    .rsp_overflow (rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_chain = '0;
  endtask

  task automatic drive_one(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic chain);
    clear_reqs();
    req_valid[r]      = 1'b1;
    req_a[r*W +: W]   = a;
    req_b[r*W +: W]   = b;
    req_cin[r]        = cin;
    req_chain[r]      = chain;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    clear_reqs();
    tick();
    tick();
    vec_cnt++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got v=%b id=%0d sum=%h c=%b o=%b, want all 0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive_one(0, 64'h5, 64'hA, 1'b1, 1'b0);
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    tick();
    clear_reqs();
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 64'h10 || rsp_cout !== 1'b0 ||
        rsp_overflow !== 1'b0 || rsp_id !== 2'd0) begin
      err_cnt++;
      $display("FAIL single_result: got v=%b id=%0d sum=%h c=%b o=%b, want v=1 id=0 sum=10 c=0 o=0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow);
    end
  endtask

  task automatic test_overflow();
    drive_one(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    tick();
    vec_cnt++;
    if (rsp_sum !== 64'h8000_0000_0000_0000 || rsp_overflow !== 1'b1 ||
        rsp_cout !== 1'b0 || rsp_id !== 2'd1) begin
      err_cnt++;
      $display("FAIL ovf_pos: got id=%0d sum=%h c=%b o=%b, want id=1 sum=8000000000000000 c=0 o=1",
               rsp_id, rsp_sum, rsp_cout, rsp_overflow);
    end
    drive_one(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    tick();
    clear_reqs();
    vec_cnt++;
    if (rsp_sum !== 64'h0 || rsp_overflow !== 1'b1 || rsp_cout !== 1'b1 || rsp_id !== 2'd3) begin
      err_cnt++;
      $display("FAIL ovf_neg: got id=%0d sum=%h c=%b o=%b, want id=3 sum=0 c=1 o=1",
               rsp_id, rsp_sum, rsp_cout, rsp_overflow);
    end
  endtask

  task automatic test_chain();
    drive_one(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    tick();
    vec_cnt++;
    if (rsp_sum !== 64'h0 || rsp_cout !== 1'b1 || rsp_id !== 2'd2) begin
      err_cnt++;
      $display("FAIL chain_low: got id=%0d sum=%h c=%b, want id=2 sum=0 c=1",
               rsp_id, rsp_sum, rsp_cout);
    end
    drive_one(2, 64'h0, 64'h0, 1'b0, 1'b1);
    tick();
    clear_reqs();
    vec_cnt++;
    if (rsp_sum !== 64'h1 || rsp_cout !== 1'b0 || rsp_id !== 2'd2) begin
      err_cnt++;
      $display("FAIL chain_high: got id=%0d sum=%h c=%b, want id=2 sum=1 c=0",
               rsp_id, rsp_sum, rsp_cout);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    logic [N-1:0] exp_gnt;
    // Pointer sits at 3 after requester 2; one op from 3 moves it to 0.
    drive_one(3, 64'h1, 64'h1, 1'b0, 1'b0);
    tick();
    vec_cnt++;
    if (rsp_sum !== 64'h2 || rsp_id !== 2'd3) begin
      err_cnt++;
      $display("FAIL rr_prime: got id=%0d sum=%h, want id=3 sum=2", rsp_id, rsp_sum);
    end
    clear_reqs();
    for (int r = 0; r < N; r++) begin
      req_valid[r]    = 1'b1;
      req_a[r*W +: W] = 64'(r);
      req_b[r*W +: W] = 64'd100;
    end
    for (int k = 0; k < 5; k++) begin
      exp_id  = 2'(k % N);
      exp_gnt = 4'b0001 << exp_id;
      #1;
      vec_cnt++;
      if (req_ready !== exp_gnt) begin
        err_cnt++;
        $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_gnt);
      end
      tick();
      vec_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_sum !== 64'd100 + 64'(exp_id)) begin
        err_cnt++;
        $display("FAIL rr_result[%0d]: got v=%b id=%0d sum=%0d, want v=1 id=%0d sum=%0d",
                 k, rsp_valid, rsp_id, rsp_sum, exp_id, 100 + int'(exp_id));
      end
    end
    clear_reqs();
  endtask

  task automatic test_back_to_back();
    // Pointer is 1 after the five-grant round; requester 0 still wins alone.
    rsp_ready = 1'b1;
    drive_one(0, 64'h1234, 64'h1, 1'b0, 1'b0);
    tick();
    rsp_ready = 1'b0;
    drive_one(1, 64'h20, 64'h22, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      vec_cnt++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_sum !== 64'h1235 ||
          rsp_id !== 2'd0 || rsp_cout !== 1'b0 || rsp_overflow !== 1'b0) begin
        err_cnt++;
        $display("FAIL hold[%0d]: got rdy=%b v=%b id=%0d sum=%h, want rdy=0000 v=1 id=0 sum=1235",
                 k, req_ready, rsp_valid, rsp_id, rsp_sum);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0010) begin
      err_cnt++;
      $display("FAIL release_ready: got %b want 0010", req_ready);
    end
    tick();
    clear_reqs();
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 64'h42 || rsp_id !== 2'd1) begin
      err_cnt++;
      $display("FAIL release_result: got v=%b id=%0d sum=%h, want v=1 id=1 sum=42",
               rsp_valid, rsp_id, rsp_sum);
    end
    tick();
    vec_cnt++;
    if (rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain_empty: got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_midop();
    drive_one(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    tick();
    clear_reqs();
    rsp_ready = 1'b0;
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_cout !== 1'b1) begin
      err_cnt++;
      $display("FAIL midop_setup: got v=%b c=%b, want v=1 c=1", rsp_valid, rsp_cout);
    end
    rst_n = 1'b0;
    tick();
    vec_cnt++;
    if (rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL midop_reset: got v=%b want 0", rsp_valid);
    end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    drive_one(2, 64'h0, 64'h0, 1'b0, 1'b1);
    tick();
    clear_reqs();
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 64'h0 || rsp_id !== 2'd2) begin
      err_cnt++;
      $display("FAIL midop_chain: got v=%b id=%0d sum=%h, want v=1 id=2 sum=0",
               rsp_valid, rsp_id, rsp_sum);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    clear_reqs();
    test_reset();
    test_single();
    test_overflow();
    test_chain();
    test_round_robin();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
Shares one combinational full_adder_64bit between NUM_REQ requesters with round-robin arbitration and valid/ready handshakes on both sides. Each grant launches one 64-bit add. The result (sum, cout, signed overflow, requester id) is held in a one-entry output register until the consumer accepts it. A per-requester carry register supports multi-word (multi-precision) additions, chained over successive grants.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 64, operand width; must match the adder instance
ID_W, $clog2(NUM_REQ), width of the requester id

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready
req_a  in  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand B, same packing
req_cin  in  NUM_REQ  carry-in, used when chain=0
req_chain  in  NUM_REQ  1 = use the stored carry of requester i instead of req_cin
rsp_valid  out  1  result register full
rsp_ready  in  1  consumer accepts the result
rsp_id  out  ID_W  index of the requester that produced the result
rsp_sum  out  DATA_W  sum
rsp_cout  out  1  unsigned carry-out
rsp_overflow  out  1  signed overflow: operand sign bits equal and sum sign bit differs

Behaviour:
- Reset: sampled on posedge clk when rst_n=0.
  - rsp_valid=0; rsp_id, rsp_sum, rsp_cout, rsp_overflow=0.
  - All carry registers=0; RR pointer=0; state=EMPTY.
  - Reset mid-operation discards any held result with no response.
- FSM states:
  - EMPTY: result register free.
  - FULL: result held, rsp_valid=1.
- can_issue = (state==EMPTY) | rsp_ready.
  - Accept and issue may occur in the same cycle, giving 1 result/cycle throughput.
- Arbitration (combinational):
  - If can_issue and any req_valid: grant the first valid requester searching from ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - req_ready = one-hot grant; otherwise all zeros.
  - req_ready may depend on req_valid.
- On grant of requester g at edge N:
  - Latch sum/cout/overflow from the adder, driven by req_a[g], req_b[g], and cin = req_chain[g] ? carry[g] : req_cin[g].
  - rsp_id=g; ptr <= (g+1) mod NUM_REQ; carry[g] <= cout.
  - rsp_valid=1 from edge N. Latency is 1 cycle from handshake to valid result.
- FULL with rsp_ready=0:
  - All outputs are held stable and req_ready=0.
  - ptr and carry registers are unchanged.
- FULL with rsp_ready=1 and no grant: go to EMPTY; rsp_valid=0.
- FULL with rsp_ready=1 and a grant: stay FULL with the new result.
- Carry registers update only on that requester's own grant. Chaining never uses another requester's carry.
- NUM_REQ not a power of two: ptr wraps explicitly from NUM_REQ-1 to 0.
- Fairness: a continuously valid requester is granted within NUM_REQ issue slots.

Decomposition:
- Package adder_sched_pkg:
  - DATA_W and ID_W defaults.
  - State enum {EMPTY, FULL}.
  - Packed result struct {id, sum, cout, overflow}.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, ptr, enable.
  - Output: one-hot grant plus encoded index.
- The scheduler instantiates one full_adder_64bit on the muxed operands.

Test Plan:
- Single op, reset:
  - rst_n=0 for 2 cycles, then requester 0 sends a=0x5, b=0xA, cin=1, rsp_ready=1.
  - Expect rsp_valid one cycle later: sum=0x10, cout=0, overflow=0, id=0.
- Overflow flags:
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1: expect sum=0x8000_0000_0000_0000, overflow=1, cout=0.
  - a=b=0x8000_0000_0000_0000: expect sum=0, cout=1, overflow=1.
- Chained 128-bit add (requester 2):
  - Low word: a=0xFFFF_FFFF_FFFF_FFFF, b=1, chain=0, cin=0 → sum=0, cout=1.
  - High word: a=0, b=0, chain=1 → sum=1, cout=0.
- Round-robin:
  - All 4 requesters hold valid, rsp_ready=1.
  - Expect grant order 0,1,2,3,0 on consecutive cycles with one result per cycle.
- Backpressure:
  - Result held with rsp_ready=0 for 5 cycles.
  - Outputs stay stable, req_ready=0.
  - When rsp_ready rises with requester 1 valid: accept and issue happen in the same cycle.
- Reset mid-op:
  - Assert rst_n=0 while FULL with carry[2]=1.
  - Next cycle: rsp_valid=0. A following chained op from requester 2 with a=b=0 returns sum=0.
